// File: rtl/rc_pkg.sv
// Shared types and constants for the remote-control frame layer: FSM encoding,
// command codes and 16 MHz timing defaults.
package rc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_SYNC = 2'd1,
        GOT_CMD  = 2'd2,
        GOT_ARG  = 2'd3
    } rc_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

    localparam logic [7:0] CMD_STOP  = 8'h00;
    localparam logic [7:0] CMD_FWD   = 8'h01;
    localparam logic [7:0] CMD_REV   = 8'h02;
    localparam logic [7:0] CMD_LEFT  = 8'h03;
    localparam logic [7:0] CMD_RIGHT = 8'h04;

    localparam int unsigned CLK_HZ = 32'd16_000_000;

    // 10 ms between bytes inside a frame, 3 s of silence before forcing stop.
    localparam logic [31:0] BYTE_TIMEOUT_DEF = 32'(CLK_HZ / 100);
    localparam logic [31:0] SLEEP_DEF        = 32'(CLK_HZ * 3);

    function automatic logic [7:0] frame_chk(input logic [7:0] sync_b,
                                             input logic [7:0] cmd_b,
                                             input logic [7:0] arg_b);
        return sync_b ^ cmd_b ^ arg_b;
    endfunction

endpackage

// File: rtl/rc_frame_ctrl_if.sv
// Byte-stream input from the UART receive core and latched command outputs
// toward the motor layer.
interface rc_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_done;
    logic [DATA_WIDTH-1:0] cmd;
    logic [DATA_WIDTH-1:0] arg;
    logic                  cmd_valid;
    logic                  frame_err;
    logic                  link_active;

    modport master (
        output rx_data, rx_done,
        input  cmd, arg, cmd_valid, frame_err, link_active
    );

    modport slave (
        input  rx_data, rx_done,
        output cmd, arg, cmd_valid, frame_err, link_active
    );
endinterface

// File: rtl/rc_timeout_cnt.sv
// Clear/enable counter that pulses tc on the cycle it reaches LIMIT and then
// restarts from zero; a clear in the same cycle suppresses the pulse.
module rc_timeout_cnt #(
    parameter logic [31:0] LIMIT = 32'd1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [31:0] cnt;

    assign tc = en && !clr && (cnt == LIMIT - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tc) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 32'd1;
        end
    end
endmodule

// File: rtl/rc_frame_ctrl.sv
// Assembles SYNC/CMD/ARG/CHK frames from the UART byte stream, latches valid
// commands and supervises the link. Define RC_FRAME_CHECKSUM_EN to verify CHK.
module rc_frame_ctrl
    import rc_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter logic [31:0]           BYTE_TIMEOUT = BYTE_TIMEOUT_DEF,
    parameter logic [31:0]           SLEEP        = SLEEP_DEF
) (
    input  logic           clk,
    input  logic           rst,
    rc_frame_ctrl_if.slave bus
);
    rc_state_t state, next_state;

    logic [DATA_WIDTH-1:0] cmd_tmp;
    logic [DATA_WIDTH-1:0] arg_tmp;

    logic chk_ok;
    logic frame_ok;
    logic frame_bad;
    logic byte_clr;
    logic byte_en;
    logic byte_tc;
    logic sleep_tc;

    logic [DATA_WIDTH-1:0] cmd_p1;
    logic [DATA_WIDTH-1:0] arg_p1;
    logic                  vld_p1;
    logic                  err_p1;
    logic                  link_p1;

    rc_timeout_cnt #(.LIMIT(BYTE_TIMEOUT)) u_byte_timer (
        .clk (clk),
        .rst (rst),
        .clr (byte_clr),
        .en  (byte_en),
        .tc  (byte_tc)
    );

    // Only a valid frame restarts the sleep window; a bad one does not.
    rc_timeout_cnt #(.LIMIT(SLEEP)) u_sleep_cnt (
        .clk (clk),
        .rst (rst),
        .clr (frame_ok),
        .en  (1'b1),
        .tc  (sleep_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A byte arriving on the timeout cycle keeps the frame alive.
    always_comb begin
        next_state = state;
        if (bus.rx_done) begin
            case (state)
                IDLE:     if (bus.rx_data == SYNC_BYTE) next_state = GOT_SYNC;
                GOT_SYNC: next_state = GOT_CMD;
                GOT_CMD:  next_state = GOT_ARG;
                GOT_ARG:  next_state = IDLE;
            endcase
        end else if (byte_tc) begin
            next_state = IDLE;
        end
    end

`ifdef RC_FRAME_CHECKSUM_EN
    assign chk_ok = (bus.rx_data == frame_chk(SYNC_BYTE, cmd_tmp, arg_tmp));
`else
    assign chk_ok = 1'b1;
`endif

    always_comb begin
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        byte_en   = (state != IDLE);
        byte_clr  = bus.rx_done || (state == IDLE);
        if (bus.rx_done && state == GOT_ARG) begin
            frame_ok  = chk_ok;
            frame_bad = !chk_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.rx_done && state == GOT_SYNC) cmd_tmp <= bus.rx_data;
        if (bus.rx_done && state == GOT_CMD)  arg_tmp <= bus.rx_data;
    end

    // ---- stage p1: registered outputs, one cycle after the CHK strobe ----
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_p1  <= '0;
            arg_p1  <= '0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
            link_p1 <= 1'b0;
        end else begin
            vld_p1 <= frame_ok;
            err_p1 <= frame_bad || byte_tc;
            if (frame_ok) begin
                cmd_p1  <= cmd_tmp;
                arg_p1  <= arg_tmp;
                link_p1 <= 1'b1;
            end else if (sleep_tc) begin
                cmd_p1  <= CMD_STOP;
                arg_p1  <= '0;
                link_p1 <= 1'b0;
            end
        end
    end

    assign bus.cmd         = cmd_p1;
    assign bus.arg         = arg_p1;
    assign bus.cmd_valid   = vld_p1;
    assign bus.frame_err   = err_p1;
    assign bus.link_active = link_p1;

endmodule

// File: doc/rc_frame_ctrl.md
Name: rc_frame_ctrl

Overview:
- Sequences the byte stream from the UART receive core (`Rx_core`) into validated remote-control command frames.
- Frame format: 4 bytes, in order SYNC, CMD, ARG, CHK.
- Drives the latched command/argument consumed by the motor layer.
- Owns link supervision: aborts a frame on inter-byte timeout, and drops to a stop command when no valid frame arrives within the sleep window.

Parameters:
- DATA_WIDTH, 8, byte width; fixed at 8 for this frame format.
- SYNC_BYTE, 8'hAA, frame start marker.
- BYTE_TIMEOUT, 32'd160000, max cycles between bytes inside a frame (10 ms at 16 MHz).
- SLEEP, 32'd48000000, cycles with no valid frame before forcing stop (3 s at 16 MHz).

Ports:
- clk  in  1  16 MHz system clock.
- rst  in  1  synchronous reset, active high.
- rx_data  in  DATA_WIDTH  byte from Rx_core; sampled only when rx_done=1.
- rx_done  in  1  one-cycle strobe, new byte valid.
- cmd  out  8  last valid command byte.
- arg  out  8  last valid argument byte.
- cmd_valid  out  1  one-cycle pulse when cmd/arg update.
- frame_err  out  1  one-cycle pulse on checksum mismatch or inter-byte timeout.
- link_active  out  1  high while a valid frame was seen within SLEEP cycles.

Behaviour:
- Single clock domain (clk). Reset is synchronous, active high, on rst.
- Reset values: cmd=0, arg=0, cmd_valid=0, frame_err=0, link_active=0, state=IDLE, both counters 0.
- FSM states: IDLE, GOT_SYNC, GOT_CMD, GOT_ARG.
  - IDLE: rx_done with rx_data==SYNC_BYTE -> GOT_SYNC. Any other byte is discarded silently; no frame_err.
  - GOT_SYNC: rx_done -> capture cmd_tmp, go to GOT_CMD. 0xAA is legal data here.
  - GOT_CMD: rx_done -> capture arg_tmp, go to GOT_ARG.
  - GOT_ARG: rx_done -> compare rx_data against SYNC_BYTE ^ cmd_tmp ^ arg_tmp (8-bit XOR).
    - Match: next cycle cmd<=cmd_tmp, arg<=arg_tmp, cmd_valid=1, link_active=1; return to IDLE.
    - Mismatch: frame_err=1 for one cycle; cmd/arg unchanged; return to IDLE.
- Latency: registered outputs update 1 cycle after the CHK byte's rx_done.
- Byte timer:
  - Counts only in the non-IDLE states; cleared on every rx_done and on entry to IDLE.
  - Reaching BYTE_TIMEOUT -> frame_err pulse, state to IDLE; outputs unchanged.
  - rx_done in the same cycle as the timeout: the byte wins, no error.
- Sleep counter:
  - Free-running; cleared only by a valid frame. A bad frame does not clear it.
  - Reaching SLEEP -> cmd<=0, arg<=0, link_active<=0, counter<=0. No cmd_valid pulse.
  - Valid frame completion in the same cycle as the sleep expiry: the frame wins; the counter clears and new values load.
- cmd_valid and frame_err are never high in the same cycle.
- rst asserted mid-frame: the partial frame is discarded and all state returns to reset values on the next edge.
- Counters are 32-bit unsigned; compare with ==. No wrap is possible, because each counter clears at its limit.

Optional Feature:
- Macro RC_FRAME_CHECKSUM_EN.
  - Defined: CHK byte verified as above.
  - Undefined: CHK byte is consumed but ignored; every complete 4-byte frame is accepted; frame_err is raised only by timeout.

Decomposition:
- Shared package rc_pkg:
  - FSM state typedef (2-bit encoding).
  - SYNC_BYTE default.
  - Command code constants: STOP=8'h00, FWD=8'h01, REV=8'h02, LEFT=8'h03, RIGHT=8'h04.
  - 16 MHz-derived timing constants.
- One natural sub-module: rc_timeout_cnt, a reusable clear/enable/limit counter with a terminal-count pulse. Instantiated twice: byte timer and sleep counter.
- Instantiated alongside Rx_core by the top-level remote-control block.

Test Plan (SLEEP=1000 and BYTE_TIMEOUT=50 overridden for the bench):
- Bytes AA,01,64,CF with 10-cycle gaps -> cmd=01, arg=64, cmd_valid single pulse one cycle after the CF strobe, link_active=1.
- Bytes AA,02,10,00 (bad CHK, correct value B8) -> frame_err single pulse; cmd/arg keep previous values; no cmd_valid.
- Bytes 55,13,AA,03,20,89 -> the leading junk is ignored; cmd=03, arg=20 accepted; no frame_err.
- AA,01 then 60 idle cycles, then AA,04,05,AB -> frame_err at cycle 50 after 01; the following frame is accepted, cmd=04, arg=05.
- Valid frame, then 1000 cycles with no rx_done -> cmd=0, arg=0, link_active=0 on exactly the 1000th cycle; no cmd_valid.
- rst pulsed after AA,01, then 64,CF -> no cmd_valid; outputs stay 0; the next full frame AA,01,64,CF is accepted.
